// File: rtl/elvm_pkg.sv
// elvm_pkg: ELVM opcode constants, putc TX state encoding and stage defaults.
package elvm_pkg;
   localparam logic [4:0] OP_PUTC = 5'b00101;
   localparam int CLKS_PER_BIT_DEF = 434;
   localparam int FIFO_DEPTH_DEF = 16;
   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
   function automatic logic even_parity(input logic [7:0] d);
      return ^d;
   endfunction
endpackage

// File: rtl/putc_uart_tx_if.sv
// putc_uart_tx_if: character write port from the ELVM core into the putc TX stage.
interface putc_uart_tx_if;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       full;
   logic       overflow;
   modport master(output wr_en, wr_data, input full, overflow);
   modport slave(input wr_en, wr_data, output full, overflow);
endinterface

// File: rtl/putc_fifo.sv
// putc_fifo: character FIFO; writes while full are dropped and flagged in a sticky overflow.
module putc_fifo #(
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [7:0]    wr_data,
   input  logic          rd_en,
   output logic [7:0]    rd_data,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty,
   output logic          overflow
);
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          do_wr, do_rd;
   logic [AW:0]   count_n;
   // a full FIFO refuses the write even if a pop frees a slot in the same cycle
   assign do_wr = wr_en & ~full;
   assign do_rd = rd_en & ~empty;
   assign empty = count == '0;
   assign rd_data = mem[rd_ptr];
   assign count_n = count + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};
   always_ff @(posedge clk)
      if (do_wr) mem[wr_ptr] <= wr_data;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         full     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + AW'(1);
         if (do_rd) rd_ptr <= rd_ptr + AW'(1);
         count <= count_n;
         full  <= count_n == (AW+1)'(DEPTH);
         if (wr_en && full) overflow <= 1'b1;
      end
endmodule

// File: rtl/putc_uart_tx.sv
// putc_uart_tx: buffers ELVM putc characters and serialises them as UART 8N1 frames.
// Define PUTC_PARITY_EN to insert an even parity bit after bit 7 (8E1).
module putc_uart_tx
   import elvm_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   putc_uart_tx_if.slave  bus,
   output logic           txd,
   output logic           busy
);
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
   tx_state_t     state;
   logic [BW-1:0] baud;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic [7:0]    rd_data;
   logic [AW:0]   count;
   logic          empty, pop, bit_end;
`ifdef PUTC_PARITY_EN
   logic          parity;
`endif
   putc_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (bus.wr_en),
      .wr_data  (bus.wr_data),
      .rd_en    (pop),
      .rd_data  (rd_data),
      .count    (count),
      .full     (bus.full),
      .empty    (empty),
      .overflow (bus.overflow)
   );
   assign bit_end = baud == '0;
   // popping at the end of STOP chains the next start bit with no idle gap
   assign pop = !empty && (state == TX_IDLE || (state == TX_STOP && bit_end));
   assign busy = state != TX_IDLE || count != '0;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state   <= TX_IDLE;
         baud    <= '0;
         bit_idx <= '0;
         shift   <= '0;
         txd     <= 1'b1;
`ifdef PUTC_PARITY_EN
         parity  <= 1'b0;
`endif
      end else if (pop) begin
         state <= TX_START;
         baud  <= BAUD_MAX;
         shift <= rd_data;
         txd   <= 1'b0;
`ifdef PUTC_PARITY_EN
         parity <= even_parity(rd_data);
`endif
      end else if (state != TX_IDLE) begin
         baud <= bit_end ? BAUD_MAX : baud - BW'(1);
         if (bit_end)
            case (state)
               TX_START: begin
                  state   <= TX_DATA;
                  bit_idx <= '0;
                  txd     <= shift[0];
               end
               TX_DATA:
                  if (bit_idx == 3'd7) begin
`ifdef PUTC_PARITY_EN
                     state <= TX_PARITY;
                     txd   <= parity;
`else
                     state <= TX_STOP;
                     txd   <= 1'b1;
`endif
                  end else begin
                     shift   <= shift >> 1;
                     txd     <= shift[1];
                     bit_idx <= bit_idx + 3'd1;
                  end
`ifdef PUTC_PARITY_EN
               TX_PARITY: begin
                  state <= TX_STOP;
                  txd   <= 1'b1;
               end
`endif
               default: state <= TX_IDLE;
            endcase
      end
endmodule

// File: tb/tb_putc_uart_tx.sv
// tb_putc_uart_tx: random and directed checks of putc_uart_tx against a line-decoding reference.
module tb_putc_uart_tx;
   localparam int CPB = 4;
   localparam int DEPTH = 16;
`ifdef PUTC_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME = NBITS * CPB;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic txd, busy;
   int n_tests = 0;
   int n_fail = 0;
   logic       trace[$];
   logic [7:0] rx_q[$];
   logic [7:0] exp_q[$];
   int         fall_q[$];

   putc_uart_tx_if bus();
   putc_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .txd   (txd),
      .busy  (busy)
   );

   always #5 clk = ~clk;
   always @(negedge clk) trace.push_back(txd);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected line level of frame bit k: start, 8 data bits LSB first, [even parity], stop.
   function automatic logic frame_bit(input logic [7:0] d, input int k);
      if (k == 0) return 1'b0;
      if (k <= 8) return d[k-1];
      if (NBITS == 11 && k == 9) return ^d;
      return 1'b1;
   endfunction

   task automatic wr(input logic [7:0] d);
      bus.wr_en = 1'b1;
      bus.wr_data = d;
      @(negedge clk);
      bus.wr_en = 1'b0;
   endtask

   task automatic wait_idle(input int limit);
      int n = 0;
      while (busy !== 1'b0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", busy, 0);
      repeat (4) @(negedge clk);
   endtask

   // Behavioural UART receiver over the recorded line: every falling start bit opens a frame
   task automatic decode(input int from);
      int i = from;
      rx_q.delete();
      fall_q.delete();
      while (i + FRAME <= trace.size()) begin
         if (trace[i] == 1'b0) begin
            logic [7:0] d;
            for (int b = 0; b < 8; b++) d[b] = trace[i + CPB*(b+1) + CPB/2];
            check("stop_bit", trace[i + CPB*(NBITS-1) + CPB/2], 1);
`ifdef PUTC_PARITY_EN
            check("parity_bit", trace[i + CPB*9 + CPB/2], ^d);
`endif
            rx_q.push_back(d);
            fall_q.push_back(i);
            i += FRAME;
         end else i++;
      end
   endtask

   task automatic expect_rx(input string tag);
      check({tag, "_count"}, rx_q.size(), exp_q.size());
      foreach (exp_q[i]) check(tag, i < rx_q.size() ? {24'h0, rx_q[i]} : 32'hdeadbeef, exp_q[i]);
   endtask

   task automatic frame_check(input logic [7:0] d);
      wr(d);
      check("busy_after_wr", busy, 1);
      check("txd_before_pop", txd, 1);
      @(negedge clk);
      check("txd_fall", txd, 0);
      for (int k = 0; k < NBITS; k++) begin
         repeat (CPB/2) @(negedge clk);
         check($sformatf("frame_%02h_bit%0d", d, k), txd, frame_bit(d, k));
         check("busy_in_frame", busy, 1);
         repeat (CPB - CPB/2) @(negedge clk);
      end
      check("busy_after_frame", busy, 0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int mark;
      bus.wr_en = 1'b0;
      bus.wr_data = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_txd", txd, 1);
      check("rst_busy", busy, 0);
      check("rst_full", bus.full, 0);
      check("rst_overflow", bus.overflow, 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      frame_check(8'h41);
`ifdef PUTC_PARITY_EN
      frame_check(8'h07);
      frame_check(8'h03);
`endif

      mark = trace.size();
      wr(8'h48);
      wr(8'h69);
      wait_idle(4 * FRAME);
      decode(mark);
      exp_q = '{8'h48, 8'h69};
      expect_rx("hi");
      check("hi_gap", fall_q.size() == 2 ? fall_q[1] - fall_q[0] : -1, FRAME);

      for (int r = 0; r < 6; r++) begin
         mark = trace.size();
         exp_q.delete();
         for (int n = $urandom_range(1, 8); n > 0; n--) begin
            logic [7:0] d = 8'($urandom);
            exp_q.push_back(d);
            wr(d);
            repeat ($urandom_range(0, 3)) @(negedge clk);
         end
         wait_idle(10 * FRAME);
         decode(mark);
         expect_rx($sformatf("rand%0d", r));
         check("rand_overflow", bus.overflow, 0);
      end

      mark = trace.size();
      exp_q.delete();
      for (int i = 0; i < DEPTH + 2; i++) begin
         wr(8'(i));
         if (i < DEPTH + 1) exp_q.push_back(8'(i));
         if (i == DEPTH - 1) check("full_after_16", bus.full, 0);
         if (i == DEPTH) begin
            check("full_after_17", bus.full, 1);
            check("overflow_before_drop", bus.overflow, 0);
         end
      end
      check("overflow_set", bus.overflow, 1);
      wait_idle((DEPTH + 2) * FRAME);
      decode(mark);
      expect_rx("ovf");
      check("overflow_sticky", bus.overflow, 1);
      check("full_drained", bus.full, 0);

      wr(8'($urandom));
      wr(8'h00);
      wr(8'($urandom));
      repeat (FRAME + CPB + 6) @(negedge clk);
      check("txd_mid_data", txd, 0);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_txd", txd, 1);
      check("async_rst_busy", busy, 0);
      check("async_rst_overflow", bus.overflow, 0);
      check("async_rst_full", bus.full, 0);
      @(negedge clk);
      rst_n = 1'b1;
      mark = trace.size();
      repeat (3 * FRAME) @(negedge clk);
      decode(mark);
      check("post_rst_frames", rx_q.size(), 0);
      check("post_rst_busy", busy, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
